vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
Single-port video RAM arbiter that sits directly downstream of the lm3 top level. It consumes the vram_cpu_* request port (driven by busint) and the vram_vga_* fetch port (driven by vga_display). It serialises both onto one synchronous block-RAM port. VGA fetches are favoured but cannot starve the CPU, and each requester gets a handshake that matches what lm3 expects.

Parameters:
RAM_RD_LATENCY, 1, cycles from ram_en (read) to valid ram_dout; legal range 1..3
ADDR_W, 15, VRAM word address width
DATA_W, 32, VRAM word width

Ports:
clk  in  1  sole clock; CPU, VGA and RAM sides are all in this domain
reset  in  1  synchronous, active-high
vram_cpu_addr  in  ADDR_W  CPU word address
vram_cpu_data_out  in  DATA_W  CPU write data
vram_cpu_req  in  1  CPU request, level, held until done
vram_cpu_write  in  1  1 = write, 0 = read; sampled at accept
vram_cpu_data_in  out  DATA_W  CPU read data
vram_cpu_ready  out  1  arbiter can accept a CPU request
vram_cpu_done  out  1  one-cycle completion pulse
vram_vga_addr  in  ADDR_W  VGA fetch address
vram_vga_req  in  1  one-cycle fetch request pulse
vram_vga_data_out  out  DATA_W  VGA fetch data
vram_vga_ready  out  1  one-cycle pulse; vram_vga_data_out valid
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable, qualified by ram_en

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; vga_pending=0; cpu_armed=1; last_vga=0; state=IDLE. Reset mid-access abandons the access with no done/ready pulse. A CPU req still high after reset is then serviced as a new request.
- All outputs are registered.
- VGA capture: a vram_vga_req pulse sets vga_pending and latches vram_vga_addr in every state.
  - A pulse while already pending overwrites the address (latest wins); no extra ready pulse.
  - A pulse during VGA service re-pends.
- CPU eligible = vram_cpu_req & cpu_armed & state==IDLE.
- vram_cpu_ready = (state==IDLE) & cpu_armed. It drops the cycle after accept and returns once cpu_armed is set again.
- Arbitration in IDLE, one grant per cycle:
  - Both eligible: CPU wins if last_vga=1, otherwise VGA wins.
  - Single requester: that requester wins.
  - last_vga is set on a VGA grant and cleared on a CPU grant.
- States:
  - IDLE → VGA_RD, CPU_RD or CPU_WR on grant. The grant cycle registers ram_addr, ram_din, ram_en=1 and ram_we.
  - VGA_RD/CPU_RD: ram_en is high for exactly one cycle (the first state cycle). A counter waits RAM_RD_LATENCY cycles, then the arbiter captures ram_dout. It asserts vram_vga_ready or vram_cpu_done for 1 cycle with the data, then returns to IDLE.
  - CPU_WR: ram_en=ram_we=1 for one cycle, then vram_cpu_done pulses the next cycle, then IDLE.
- CPU acceptance clears cpu_armed. cpu_armed sets again only after vram_cpu_req is sampled low, so a held req never double-issues.
- vga_pending clears on grant, unless a new pulse arrives in the grant cycle, in which case it stays set with the new address.
- Timing at RAM_RD_LATENCY=1, with req sampled in IDLE at cycle 0:
  - ram_en at cycle 1; done/ready at cycle 3; next grant possible at cycle 4.
  - Write: ram_en/ram_we at cycle 1; done at cycle 2.
- vram_cpu_data_in and vram_vga_data_out hold their last captured value between transfers.
- Address width is a plain ADDR_W pass-through with no wrap logic; address 0x7FFF is legal.
- ram_we is never high without ram_en. ram_en is never high outside the first cycle of an access.

Test Plan:
- CPU write then read: write 0xDEADBEEF to 0x0123 → ram_we pulse with addr 0x0123, done at cycle 2. Read 0x0123 → vram_cpu_data_in=0xDEADBEEF, done at cycle 3, exactly one done per request.
- VGA fetch: preload 0x7FFF=0x12345678, pulse vga_req addr 0x7FFF → vram_vga_ready at cycle 3 with data 0x12345678. No CPU outputs change.
- Simultaneous requests with last_vga=0: CPU read 0x0010 and VGA 0x0020 in the same cycle → VGA served first (ready at cycle 3), CPU granted at cycle 4, done at cycle 6.
- Fairness: VGA pulses every 4 cycles while the CPU holds req through 10 requests → CPU granted at least every other slot and every CPU request completes.
- Held req: CPU holds req high 20 cycles after done → single RAM access, vram_cpu_ready stays low until req drops. After req drops, ready=1 the next cycle.
- Reset mid-read: assert reset at cycle 2 of a CPU read → no done pulse, all outputs 0 after reset. Req still high → fresh access starts with ram_en 1 cycle after reset release.
- RAM_RD_LATENCY=3: VGA read → ready at cycle 5.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Signal bundle around vram_arbiter: CPU request port, VGA fetch port and the single block-RAM port.
// "slave" is the arbiter's view; "master" is the view of the requesters and the RAM.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] vram_cpu_addr;
  logic [DATA_W-1:0] vram_cpu_data_out;
  logic              vram_cpu_req;
  logic              vram_cpu_write;
  logic [DATA_W-1:0] vram_cpu_data_in;
  logic              vram_cpu_ready;
  logic              vram_cpu_done;
  logic [ADDR_W-1:0] vram_vga_addr;
  logic              vram_vga_req;
  logic [DATA_W-1:0] vram_vga_data_out;
  logic              vram_vga_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_en;
  logic              ram_we;

  modport slave (
    input  vram_cpu_addr, vram_cpu_data_out, vram_cpu_req, vram_cpu_write,
    output vram_cpu_data_in, vram_cpu_ready, vram_cpu_done,
    input  vram_vga_addr, vram_vga_req,
    output vram_vga_data_out, vram_vga_ready,
    output ram_addr, ram_din, ram_en, ram_we,
    input  ram_dout
  );

  modport master (
    output vram_cpu_addr, vram_cpu_data_out, vram_cpu_req, vram_cpu_write,
    input  vram_cpu_data_in, vram_cpu_ready, vram_cpu_done,
    output vram_vga_addr, vram_vga_req,
    input  vram_vga_data_out, vram_vga_ready,
    input  ram_addr, ram_din, ram_en, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: serialises CPU accesses and VGA fetches onto one synchronous block RAM.
// VGA is favoured, but a CPU waiting behind a VGA grant always wins the next slot.
module vram_arbiter #(
  parameter int unsigned RAM_RD_LATENCY = 1,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 32
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VGA_RD, CPU_RD, CPU_WR} state_e;
  localparam logic [1:0] LAT = 2'(RAM_RD_LATENCY);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vga_pending_q, vga_pending_d;
  logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
  logic              cpu_armed_q, cpu_armed_d;
  logic              last_vga_q, last_vga_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              cpu_done_q, cpu_done_d;
  logic              vga_ready_q, vga_ready_d;
  logic              vga_elig, cpu_elig;
  logic [ADDR_W-1:0] vga_gaddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      vga_pending_q <= 1'b0;
      vga_addr_q    <= '0;
      cpu_armed_q   <= 1'b1;
      last_vga_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      cpu_data_q    <= '0;
      vga_data_q    <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_done_q    <= 1'b0;
      vga_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vga_pending_q <= vga_pending_d;
      vga_addr_q    <= vga_addr_d;
      cpu_armed_q   <= cpu_armed_d;
      last_vga_q    <= last_vga_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      cpu_data_q    <= cpu_data_d;
      vga_data_q    <= vga_data_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_done_q    <= cpu_done_d;
      vga_ready_q   <= vga_ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vga_pending_d = vga_pending_q;
    vga_addr_d    = vga_addr_q;
    cpu_armed_d   = cpu_armed_q;
    last_vga_d    = last_vga_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    cpu_data_d    = cpu_data_q;
    vga_data_d    = vga_data_q;
    cpu_done_d    = 1'b0;
    vga_ready_d   = 1'b0;

    // A live VGA pulse is grantable in the same cycle; an older pending address is served first.
    vga_elig  = vga_pending_q | bus.vram_vga_req;
    vga_gaddr = vga_pending_q ? vga_addr_q : bus.vram_vga_addr;
    cpu_elig  = bus.vram_cpu_req & cpu_armed_q;

    if (!bus.vram_cpu_req) cpu_armed_d = 1'b1;
    if (bus.vram_vga_req) begin
      vga_pending_d = 1'b1;
      vga_addr_d    = bus.vram_vga_addr;
    end

    case (state_q)
      IDLE: begin
        if (vga_elig && !(cpu_elig && last_vga_q)) begin
          state_d       = VGA_RD;
          ram_addr_d    = vga_gaddr;
          ram_en_d      = 1'b1;
          last_vga_d    = 1'b1;
          cnt_d         = '0;
          vga_pending_d = vga_pending_q & bus.vram_vga_req;
        end else if (cpu_elig) begin
          state_d     = bus.vram_cpu_write ? CPU_WR : CPU_RD;
          ram_addr_d  = bus.vram_cpu_addr;
          ram_din_d   = bus.vram_cpu_data_out;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.vram_cpu_write;
          last_vga_d  = 1'b0;
          cpu_armed_d = 1'b0;
          cnt_d       = '0;
        end
      end
      VGA_RD: begin
        if (cnt_q == LAT) begin
          vga_data_d  = bus.ram_dout;
          vga_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CPU_RD: begin
        if (cnt_q == LAT) begin
          cpu_data_d = bus.ram_dout;
          cpu_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CPU_WR: begin
        cpu_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cpu_ready_d = (state_d == IDLE) & cpu_armed_d;
  end

  assign bus.ram_addr          = ram_addr_q;
  assign bus.ram_din           = ram_din_q;
  assign bus.ram_en            = ram_en_q;
  assign bus.ram_we            = ram_we_q;
  assign bus.vram_cpu_data_in  = cpu_data_q;
  assign bus.vram_cpu_ready    = cpu_ready_q;
  assign bus.vram_cpu_done     = cpu_done_q;
  assign bus.vram_vga_data_out = vga_data_q;
  assign bus.vram_vga_ready    = vga_ready_q;
endmodule
